// File: rtl/input_pkg.sv
// Shared types and board-default timing for the push-button front end.
package input_pkg;

    // Hold/auto-repeat state per channel
    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_DELAY  = 2'd1,
        H_REPEAT = 2'd2
    } hold_state_t;

    // Default timing for the 25 MHz board clock
    localparam int CLK_HZ            = 25_000_000;
    localparam int DEF_DEBOUNCE      = CLK_HZ / 100;  // 10 ms
    localparam int DEF_REPEAT_DELAY  = CLK_HZ / 2;    // 500 ms
    localparam int DEF_REPEAT_PERIOD = CLK_HZ / 10;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debouncer, edge pulses and hold/auto-repeat FSM.
module btn_channel
    import input_pkg::*;
#(
    parameter int ACTIVE_LOW      = 0,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic rel,
    output logic held
);

    localparam logic PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int   DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   HW       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic          sync1, sync2, s;
    logic [DW-1:0] dcnt;
    logic          accept, rise, fall;

    hold_state_t   state, state_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic          held_nx, rep;

    // Two-flop synchroniser, resting at the not-pressed pin value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle
    assign accept = (s != level) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise   = accept &  s;
    assign fall   = accept & ~s;

    // Debounce counter and accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt  <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            dcnt <= '0;
        end else if (accept) begin
            dcnt  <= '0;
            level <= s;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    // Hold FSM next-state; a fall always wins so release never coincides with a repeat
    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        held_nx  = held;
        rep      = 1'b0;
        if (fall) begin
            state_nx = H_IDLE;
            hcnt_nx  = '0;
            held_nx  = 1'b0;
        end else begin
            case (state)
                H_IDLE: begin
                    if (rise) begin
                        state_nx = H_DELAY;
                        hcnt_nx  = '0;
                    end
                end
                H_DELAY: begin
                    if (hcnt == HW'(REPEAT_DELAY - 1)) begin
                        state_nx = H_REPEAT;
                        hcnt_nx  = '0;
                        held_nx  = 1'b1;
                        rep      = repeat_en;
                    end else begin
                        hcnt_nx = hcnt + HW'(1);
                    end
                end
                H_REPEAT: begin
                    // Counter runs regardless of repeat_en to keep the period grid
                    if (hcnt == HW'(REPEAT_PERIOD - 1)) begin
                        hcnt_nx = '0;
                        rep     = repeat_en;
                    end else begin
                        hcnt_nx = hcnt + HW'(1);
                    end
                end
                default: begin
                    state_nx = H_IDLE;
                    hcnt_nx  = '0;
                    held_nx  = 1'b0;
                end
            endcase
        end
    end

    // Hold FSM state and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= H_IDLE;
            hcnt  <= '0;
            held  <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
            held  <= held_nx;
            press <= rise | rep;
            rel   <= fall;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: NUM_BTN independent conditioned channels.
module btn_conditioner
    import input_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int ACTIVE_LOW      = 0,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_held
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (btn_raw[g]),
            .repeat_en (repeat_en[g]),
            .level     (btn_level[g]),
            .press     (btn_press[g]),
            .rel       (btn_release[g]),
            .held      (btn_held[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: table-driven segments plus hand sequences, scoreboard-checked.
module tb_btn_conditioner;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] raw, ren, raw_al, ren_al;
    logic [NB-1:0] lvl1, prs1, rel1, hld1;
    logic [NB-1:0] lvl2, prs2, rel2, hld2;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] e1;   // {level, press, release, held} active-high DUT
        logic [15:0] e2;   // same, active-low DUT
    } exp_t;

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] ren;
        logic [15:0]   e;
        int            len;
    } seg_t;

    exp_t sb[$];
    exp_t mon_e;
    seg_t tbl[$];

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN(NB), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw), .repeat_en(ren),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1), .btn_held(hld1)
    );

    btn_conditioner #(
        .NUM_BTN(NB), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw_al), .repeat_en(ren_al),
        .btn_level(lvl2), .btn_press(prs2), .btn_release(rel2), .btn_held(hld2)
    );

    function automatic logic [15:0] ex(input logic [3:0] l, input logic [3:0] p,
                                       input logic [3:0] r, input logic [3:0] h);
        return {l, p, r, h};
    endfunction

    function automatic seg_t mk(input logic [3:0] rw, input logic [3:0] re, input logic [3:0] l,
                                input logic [3:0] p, input logic [3:0] r, input logic [3:0] h,
                                input int n);
        seg_t t;
        t.raw = rw; t.ren = re; t.e = ex(l, p, r, h); t.len = n;
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got {lvl,prs,rel,hld}=%h, expected %h", name, $time, act, expv);
        end
    endtask

    // Pop one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("dut", {lvl1, prs1, rel1, hld1}, mon_e.e1);
            check("dut_al", {lvl2, prs2, rel2, hld2}, mon_e.e2);
        end
    end

    // Drive one cycle of stimulus just after the edge and queue what that cycle must show
    task automatic cyc(input logic [3:0] rw, input logic [3:0] re, input logic [3:0] al,
                       input logic [15:0] e1, input logic [15:0] e2);
        @(posedge clk);
        #1;
        raw    = rw;
        ren    = re;
        raw_al = al;
        sb.push_back('{e1: e1, e2: e2});
    endtask

    initial begin
        rst_n  = 1'b0;
        raw    = '0;
        ren    = '0;
        raw_al = '1;
        ren_al = '0;

        // Glitch on channel 1: three high cycles, no activity
        tbl.push_back(mk(4'b0010, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 3));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 8));
        // Clean press/release on channel 2, released before the hold point
        tbl.push_back(mk(4'b0100, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 6));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'h4, 4'h4, 4'h0, 4'h0, 1));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'h4, 4'h0, 4'h0, 4'h0, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h4, 4'h0, 4'h0, 4'h0, 6));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'h4, 4'h0, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 5));
        // Auto-repeat on channel 0, repeat_en dropped at 20 and restored at 23
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 6));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h1, 4'h0, 4'h0, 1));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h0, 4'h0, 4'h0, 9));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h1, 4'h0, 4'h1, 1));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h0, 4'h0, 4'h1, 2));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h1, 4'h0, 4'h1, 1));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'h1, 4'h0, 4'h0, 4'h1, 3));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h0, 4'h0, 4'h1, 2));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h1, 4'h0, 4'h1, 1));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'h1, 4'h0, 4'h0, 4'h1, 2));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h1, 4'h1, 4'h0, 4'h1, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h1, 4'h0, 4'h0, 4'h1, 5));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'h1, 4'h0, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4));
        // All channels together, repeats disabled
        tbl.push_back(mk(4'b1111, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 6));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'hF, 4'hF, 4'h0, 4'h0, 1));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'hF, 4'h0, 4'h0, 4'h0, 9));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'hF, 4'h0, 4'h0, 4'hF, 6));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'hF, 4'h0, 4'h0, 4'hF, 6));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'hF, 4'h0, 1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 3));

        // Reset state
        #2;
        check("reset_state", {lvl1, prs1, rel1, hld1}, 16'h0);
        check("reset_state_al", {lvl2, prs2, rel2, hld2}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].len; k++)
                cyc(tbl[i].raw, tbl[i].ren, 4'hF, tbl[i].e, 16'h0);
        end

        // Async reset mid-hold on channel 0, button kept pressed through reset
        for (int c = 0; c < 18; c++)
            cyc(4'b0001, 4'b0001, 4'hF,
                ex((c >= 6) ? 4'h1 : 4'h0, (c == 6 || c == 16) ? 4'h1 : 4'h0, 4'h0,
                   (c >= 16) ? 4'h1 : 4'h0), 16'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {lvl1, prs1, rel1, hld1}, 16'h0);
        cyc(4'b0001, 4'b0001, 4'hF, 16'h0, 16'h0);
        cyc(4'b0001, 4'b0001, 4'hF, 16'h0, 16'h0);
        for (int c = 0; c < 16; c++) begin
            cyc(c < 8 ? 4'b0001 : 4'b0000, 4'b0001, 4'hF,
                ex((c >= 6 && c < 14) ? 4'h1 : 4'h0, (c == 6) ? 4'h1 : 4'h0,
                   (c == 14) ? 4'h1 : 4'h0, 4'h0), 16'h0);
            if (c == 0) rst_n = 1'b1;
        end

        // Active-low instance: channel 0 pin driven low
        for (int c = 0; c < 18; c++)
            cyc(4'b0000, 4'b0000, c < 8 ? 4'b1110 : 4'b1111, 16'h0,
                ex((c >= 6 && c < 14) ? 4'h1 : 4'h0, (c == 6) ? 4'h1 : 4'h0,
                   (c == 14) ? 4'h1 : 4'h0, 4'h0));

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
